// File: rtl/hd_link_pkg.sv
// rtl/hd_link_pkg.sv - shared constants and state encoding for the half-duplex link master
package hd_link_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_BIT_CYC  = 4;
  localparam int unsigned DEF_TURN_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_TURN1 = 3'd2,
    ST_READ  = 3'd3,
    ST_TURN2 = 3'd4
  } hd_state_e;

  // Counter width for a count of n (0..n-1); never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hd_bit_timer.sv
// rtl/hd_bit_timer.sv - phase/bit/turnaround counters for the link master
module hd_bit_timer
  import hd_link_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned BIT_CYC  = DEF_BIT_CYC,
  parameter int unsigned TURN_CYC = DEF_TURN_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic bit_end_o,
  output logic word_end_o,
  output logic turn_end_o
);

  localparam int unsigned PH_W  = cnt_width(BIT_CYC);
  localparam int unsigned BIT_W = cnt_width(DATA_W);
  localparam int unsigned TN_W  = cnt_width(TURN_CYC);

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [TN_W-1:0]  turn_q, turn_d;

  assign bit_end_o  = (phase_q == PH_W'(BIT_CYC - 1));
  assign word_end_o = bit_end_o && (bit_q == BIT_W'(DATA_W - 1));
  assign turn_end_o = (turn_q == TN_W'(TURN_CYC - 1));

  // Advance the counters; a state change restarts every count from zero.
  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    turn_d  = turn_q;
    if (clear_i) begin
      phase_d = '0;
      bit_d   = '0;
      turn_d  = '0;
    end else if (run_i) begin
      turn_d = turn_end_o ? '0 : turn_q + 1'b1;
      if (bit_end_o) begin
        phase_d = '0;
        bit_d   = word_end_o ? '0 : bit_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      bit_q   <= '0;
      turn_q  <= '0;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
      turn_q  <= turn_d;
    end
  end

endmodule

// File: rtl/hd_link_master.sv
// rtl/hd_link_master.sv - half-duplex single-wire link master (write word, turn, read word)
module hd_link_master
  import hd_link_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned BIT_CYC  = DEF_BIT_CYC,
  parameter int unsigned TURN_CYC = DEF_TURN_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              wr,
  output logic              rd,
  inout  wire               line,
  output logic              busy
);

  hd_state_e state_q, state_d;

  logic wr_q, wr_d;
  logic rd_q, rd_d;
  logic tx_ready_q, tx_ready_d;
  logic busy_q, busy_d;
  logic rx_valid_q, rx_valid_d;

  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] rx_next;

  logic accept;
  logic bit_end;
  logic word_end;
  logic turn_end;

  assign accept  = tx_valid && tx_ready_q;
  assign rx_next = {rx_sh_q[DATA_W-2:0], line};

  hd_bit_timer #(
    .DATA_W  (DATA_W),
    .BIT_CYC (BIT_CYC),
    .TURN_CYC(TURN_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d != state_q),
    .run_i     (state_q != ST_IDLE),
    .bit_end_o (bit_end),
    .word_end_o(word_end),
    .turn_end_o(turn_end)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: write word, turnaround, read word, turnaround, back to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)   state_d = ST_WRITE;
      ST_WRITE: if (word_end) state_d = ST_TURN1;
      ST_TURN1: if (turn_end) state_d = ST_READ;
      ST_READ:  if (word_end) state_d = ST_TURN2;
      ST_TURN2: if (turn_end) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    wr_d       = (state_d == ST_WRITE);
    rd_d       = (state_d == ST_READ);
    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    rx_valid_d = (state_q == ST_READ) && (state_d == ST_TURN2);
  end

  // Output registers; reset drops the strobes immediately, releasing the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Shifters: tx moves left after each bit period, rx samples on the last clock of each bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      if (accept) begin
        tx_sh_q <= tx_data;
        rx_sh_q <= '0;
      end else if ((state_q == ST_WRITE) && bit_end) begin
        tx_sh_q <= tx_sh_q << 1;
      end
      if ((state_q == ST_READ) && bit_end) begin
        rx_sh_q <= rx_next;
        if (word_end) rx_data_q <= rx_next;
      end
    end
  end

  assign line     = wr_q ? tx_sh_q[DATA_W-1] : 1'bz;
  assign wr       = wr_q;
  assign rd       = rd_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule
